// File: rtl/bta_batch_scheduler.sv
// Purpose : collects up to N operands into a buffer, launches one shared tree adder per batch,
//           then returns the captured sum. Outputs are decoded from flops only, with no input-to-output path.
// Latency : a full batch with back-to-back beats gives out_valid N+ADD_LAT+1 cycles after its first beat.
// Backpr. : in_ready is low from ISSUE through HOLD. The result is held until out_ready is seen.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   in_valid/in_ready/in_data    operand stream; in_last closes a partial batch; in_cin taken on the first beat
//   add_ops/add_cin/add_start    launch interface to the external adder (slot k = add_ops[k*M +: M])
//   add_sum/add_carry            adder result, valid ADD_LAT cycles after add_start
//   out_valid/out_ready          result handshake carrying out_sum, out_carry and out_count
//   busy                         high unless idle in COLLECT with an empty buffer
module bta_batch_scheduler #(
  parameter int N       = 8,
  parameter int M       = 16,
  parameter int ADD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_data,
  input  logic           in_last,
  input  logic           in_cin,
  output logic [N*M-1:0] add_ops,
  output logic           add_cin,
  output logic           add_start,
  input  logic [M+2:0]   add_sum,
  input  logic           add_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+2:0]   out_sum,
  output logic           out_carry,
  output logic [3:0]     out_count,
  output logic           busy
);

  localparam int         WW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [3:0] NM1 = 4'(N - 1);

  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [N*M-1:0]   slots_q;
  logic [3:0]       count_q;
  logic             cin_q;
  logic [WW-1:0]    wcnt_q;
  logic [M+2:0]     sum_q;
  logic             carry_q;
  logic [3:0]       ocount_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic. In COLLECT, in_ready is always 1, so in_valid alone marks an accepted beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_valid && (in_last || count_q == NM1)) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wcnt_q == '0) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Buffer, wait counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= '0;
      count_q  <= '0;
      cin_q    <= 1'b0;
      wcnt_q   <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ocount_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            for (int k = 0; k < N; k++) begin
              if (count_q == 4'(k)) slots_q[k*M +: M] <= in_data;
            end
            if (count_q == 4'd0) cin_q <= in_cin;
            count_q <= count_q + 4'd1;
          end
        end
        ISSUE: wcnt_q <= WW'(ADD_LAT - 1);
        WAIT: begin
          if (wcnt_q == '0) begin
            sum_q    <= add_sum;
            carry_q  <= add_carry;
            ocount_q <= count_q;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        HOLD: begin
          // Clearing the slots keeps a later partial batch from summing stale operands.
          if (out_ready) begin
            slots_q <= '0;
            count_q <= '0;
            cin_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from flops only
  always_comb begin
    in_ready  = (state_q == COLLECT);
    add_start = (state_q == ISSUE);
    out_valid = (state_q == HOLD);
    busy      = (state_q != COLLECT) || (count_q != 4'd0);
    add_ops   = slots_q;
    add_cin   = cin_q;
    out_sum   = sum_q;
    out_carry = carry_q;
    out_count = ocount_q;
  end

endmodule

// File: tb/tb_bta_batch_scheduler.sv
// Purpose : directed, table-driven bench for bta_batch_scheduler with a registered one-cycle tree adder model.
// Latency : checks add_start and out_valid cycle positions relative to the first beat of a batch.
// Backpr. : holds out_ready low in HOLD, drives in_valid while blocked, and resets mid-WAIT.
module tb_bta_batch_scheduler;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_data;
  logic           in_last;
  logic           in_cin;
  logic [127:0]   add_ops;
  logic           add_cin;
  logic           add_start;
  logic [18:0]    add_sum;
  logic           add_carry;
  logic           out_valid;
  logic           out_ready;
  logic [18:0]    out_sum;
  logic           out_carry;
  logic [3:0]     out_count;
  logic           busy;

  int ntests = 0;
  int nfail  = 0;

  bta_batch_scheduler #(.N(8), .M(16), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_cin(in_cin),
    .add_ops(add_ops), .add_cin(add_cin), .add_start(add_start),
    .add_sum(add_sum), .add_carry(add_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External adder stand-in: registered, one cycle of latency.
  function automatic logic [19:0] tree_sum(input logic [127:0] ops, input logic c);
    logic [19:0] acc;
    acc = 20'(c);
    for (int k = 0; k < 8; k++) acc = acc + 20'(ops[k*16 +: 16]);
    return acc;
  endfunction

  always @(posedge clk) {add_carry, add_sum} <= tree_sum(add_ops, add_cin);

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {in_ready, add_start, add_cin, out_valid, out_carry, busy}, 6'b100000);
    chk({tag, "_ops"}, add_ops, 128'd0);
    chk({tag, "_res"}, {out_sum, out_count}, 23'd0);
  endtask

  typedef struct {
    int               nbeats;
    logic [7:0][15:0] ops;       // slot k = ops[k]; unused slots zero
    logic             cin;
    logic             use_last;
    logic [18:0]      exp_sum;
    logic [3:0]       exp_count;
    int               exp_start;
    int               exp_valid;
  } vec_t;

  // Streams one batch starting just after a rising edge and returns at the falling edge of the first
  // out_valid cycle. With gap set, beats are offered only on even cycles.
  task automatic send_batch(input string tag, input vec_t v, input bit gap);
    int               c, i, t_start, t_valid, n_start;
    logic [127:0]     ops_at_start;
    logic             cin_at_start;
    c = 0; i = 0; t_start = -1; t_valid = -1; n_start = 0;
    ops_at_start = '0; cin_at_start = 1'b0;
    while (c < 60) begin
      if (i < v.nbeats && (!gap || (c % 2 == 0))) begin
        in_valid = 1'b1;
        in_data  = v.ops[i];
        in_cin   = v.cin;
        in_last  = v.use_last && (i == v.nbeats - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      if (add_start) begin
        n_start++;
        if (t_start < 0) begin
          t_start      = c;
          ops_at_start = add_ops;
          cin_at_start = add_cin;
        end
      end
      if (in_valid && in_ready) i++;
      if (out_valid) begin
        t_valid = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_no_timeout"}, (t_valid >= 0) ? 1 : 0, 1);
    chk({tag, "_t_start"}, t_start, v.exp_start);
    chk({tag, "_t_valid"}, t_valid, v.exp_valid);
    chk({tag, "_n_start"}, n_start, 1);
    chk({tag, "_ops"}, ops_at_start, v.ops);
    chk({tag, "_cin"}, cin_at_start, v.cin);
    chk({tag, "_sum"}, out_sum, v.exp_sum);
    chk({tag, "_carry"}, out_carry, 1'b0);
    chk({tag, "_count"}, out_count, v.exp_count);
    chk({tag, "_hold_ctl"}, {in_ready, busy}, 2'b01);
  endtask

  // Handshake the held result from a falling edge in HOLD, then return just after a rising edge.
  task automatic release_hold(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk({tag, "_released"}, {in_ready, out_valid, busy, add_ops}, {3'b100, 128'd0});
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  vec_t v;
  int   bad;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_cin = 1'b0; out_ready = 1'b0;

    // Sequential operands 1..8, carry-in clear.
    vecs[0].nbeats = 8; vecs[0].cin = 1'b0; vecs[0].use_last = 1'b0;
    for (int k = 0; k < 8; k++) vecs[0].ops[k] = 16'(k + 1);
    vecs[0].exp_sum = 19'd36; vecs[0].exp_count = 4'd8; vecs[0].exp_start = 8; vecs[0].exp_valid = 10;
    // Same operands with carry-in set.
    vecs[1] = vecs[0]; vecs[1].cin = 1'b1; vecs[1].exp_sum = 19'd37;
    // Eight maximum operands plus carry-in: no wrap at M+3 bits.
    vecs[2].nbeats = 8; vecs[2].cin = 1'b1; vecs[2].use_last = 1'b0;
    for (int k = 0; k < 8; k++) vecs[2].ops[k] = 16'hFFFF;
    vecs[2].exp_sum = 19'h7FFF9; vecs[2].exp_count = 4'd8; vecs[2].exp_start = 8; vecs[2].exp_valid = 10;
    // Partial batch right after a full one: slots 3..7 must read zero.
    vecs[3].nbeats = 3; vecs[3].cin = 1'b0; vecs[3].use_last = 1'b1; vecs[3].ops = '0;
    vecs[3].ops[0] = 16'h0100; vecs[3].ops[1] = 16'h0200; vecs[3].ops[2] = 16'h0300;
    vecs[3].exp_sum = 19'h00600; vecs[3].exp_count = 4'd3; vecs[3].exp_start = 3; vecs[3].exp_valid = 5;
    // in_last on the eighth beat behaves like a full batch.
    vecs[4].nbeats = 8; vecs[4].cin = 1'b0; vecs[4].use_last = 1'b1;
    for (int k = 0; k < 8; k++) vecs[4].ops[k] = 16'd3;
    vecs[4].exp_sum = 19'd24; vecs[4].exp_count = 4'd8; vecs[4].exp_start = 8; vecs[4].exp_valid = 10;
    // Single-beat batch carrying carry-in.
    vecs[5].nbeats = 1; vecs[5].cin = 1'b1; vecs[5].use_last = 1'b1; vecs[5].ops = '0;
    vecs[5].ops[0] = 16'h1234;
    vecs[5].exp_sum = 19'h01235; vecs[5].exp_count = 4'd1; vecs[5].exp_start = 1; vecs[5].exp_valid = 3;

    // Reset state, both while held in reset and just after release.
    #12;
    chk_reset("rst_held");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_idle");
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) begin
      send_batch($sformatf("v%0d", n), vecs[n], 1'b0);
      release_hold($sformatf("v%0d", n));
    end

    // Backpressure: the result must stay put for 5 cycles while a producer is already pushing.
    v.nbeats = 8; v.cin = 1'b0; v.use_last = 1'b0;
    for (int k = 0; k < 8; k++) v.ops[k] = 16'h0AAA;
    v.exp_sum = 19'h05550; v.exp_count = 4'd8; v.exp_start = 8; v.exp_valid = 10;
    send_batch("bp_first", v, 1'b0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'h0001; in_cin = 1'b0;
      @(negedge clk);
      if (!out_valid || out_sum !== 19'h05550 || in_ready || add_start) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    release_hold("bp_first");
    for (int k = 0; k < 8; k++) v.ops[k] = 16'h0001;
    v.exp_sum = 19'd8;
    send_batch("bp_next", v, 1'b0);
    release_hold("bp_next");

    // Reset during WAIT: the aborted batch never produces a result.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = 16'd5; in_cin = 1'b1; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rw_issue", add_start, 1'b1);
    @(negedge clk);
    chk("rw_in_wait", {busy, out_valid, add_start, in_ready}, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk_reset("rw_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid || busy || !in_ready || out_sum !== 19'd0) bad++;
    end
    chk("rw_no_stale_result", bad, 0);
    @(posedge clk); #1;
    v.nbeats = 2; v.cin = 1'b0; v.use_last = 1'b1; v.ops = '0;
    v.ops[0] = 16'd2; v.ops[1] = 16'd2;
    v.exp_sum = 19'd4; v.exp_count = 4'd2; v.exp_start = 2; v.exp_valid = 4;
    send_batch("rw_fresh", v, 1'b0);
    release_hold("rw_fresh");

    // Gapped input: beats on even cycles only, last beat in cycle 14.
    v.nbeats = 8; v.cin = 1'b0; v.use_last = 1'b0;
    for (int k = 0; k < 8; k++) v.ops[k] = 16'h1000;
    v.exp_sum = 19'h08000; v.exp_count = 4'd8; v.exp_start = 15; v.exp_valid = 17;
    send_batch("gap", v, 1'b1);
    release_hold("gap");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
